fpadd_align_shift_r: RTL and testbench

FPADD_ALIGN_SHIFT_R -- requirements
Module: fpadd_align_shift_r

---
 rtl/fpadd_align_shift_r.sv | 95 +++++++++
 tb/tb_fpadd_align_shift_r.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_align_shift_r.sv
// Right-shift aligner for the FP adder: shifts {fA, guard, round} by n using one
// log-shifter stage per cycle, collecting dropped bits into sticky.
module fpadd_align_shift_r #(
  parameter int wE = 4,
  parameter int wF = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [wF+1:0] fA,
  input  logic [wE:0]   n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [wF+3:0] fR,
  output logic          sticky
);

  localparam int W      = wF + 4;
  localparam int STAGES = $clog2(W);
  localparam int CW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(STAGES - 1);
  localparam logic [wE+1:0]  WN   = (wE + 2)'(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_work;
  logic              r_sticky;
  logic [wE:0]       r_n;
  logic [CW-1:0]     r_cnt;
  logic              r_fa_nz;

  logic              w_accept;
  logic              w_last;
  logic              w_sat;
  logic [STAGES-1:0] w_nlo;
  int                w_shamt;
  logic [W-1:0]      w_mask;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_sat    = ({1'b0, r_n} >= WN);
  assign w_nlo    = r_n[STAGES-1:0];
  assign w_shamt  = 1 << r_cnt;
  assign w_mask   = ~({W{1'b1}} << w_shamt);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign fR        = r_work;
  assign sticky    = r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_sticky <= 1'b0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_fa_nz  <= 1'b0;
    end else if (w_accept) begin
      r_work   <= {fA, 2'b00};
      r_n      <= n;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_fa_nz  <= |fA;
    end else if (r_state == SHIFT) begin
      // Shift amounts of W or more flush everything into sticky
      if (w_last && w_sat) begin
        r_work   <= '0;
        r_sticky <= r_fa_nz;
      end else if (w_nlo[r_cnt]) begin
        r_work   <= r_work >> w_shamt;
        r_sticky <= r_sticky | (|(r_work & w_mask));
      end
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fpadd_align_shift_r.sv
// Scoreboard bench for fpadd_align_shift_r: directed vectors push expectations,
// a negedge monitor checks results, latency, stall stability and in_ready recovery.
module tb_fpadd_align_shift_r;

  localparam int STAGES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] fA = '0;
  logic [4:0] n = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [8:0] fR;
  logic       sticky;

  fpadd_align_shift_r #(.wE(4), .wF(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fA(fA), .n(n), .out_valid(out_valid), .out_ready(out_ready),
    .fR(fR), .sticky(sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] fr;
    logic       st;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic       prev_ov = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [8:0] prev_fr = '0;
  logic       prev_st = 1'b0;
  logic       exp_ir = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      exp_ir  = 1'b0;
    end else begin
      if (exp_ir) begin
        chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
        exp_ir = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else chk("latency", cyc - q[0].acc, STAGES);
      end
      if (out_valid && prev_ov && !prev_rdy) begin
        chk("stall_fR_stable", {23'd0, fR}, {23'd0, prev_fr});
        chk("stall_sticky_stable", {31'd0, sticky}, {31'd0, prev_st});
      end
      if (out_valid && out_ready && q.size() != 0) begin
        chk("fR", {23'd0, fR}, {23'd0, q[0].fr});
        chk("sticky", {31'd0, sticky}, {31'd0, q[0].st});
        void'(q.pop_front());
        exp_ir = 1'b1;
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      prev_fr  = fR;
      prev_st  = sticky;
    end
  end

  task automatic do_op(input logic [6:0] a, input logic [4:0] sh,
                       input logic [8:0] efr, input logic est, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    fA = a;
    n  = sh;
    @(posedge clk); #1;
    if (push) q.push_back('{fr: efr, st: est, acc: cyc});
    in_valid = 1'b0;
    fA = $urandom_range(0, 127);
    n  = $urandom_range(0, 31);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fR", {23'd0, fR}, 32'd0);
    chk("rst_sticky", {31'd0, sticky}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic alignments
    do_op(7'b1000001, 5'd2,  9'b001000001, 1'b0, 1'b1);
    wait_empty();
    do_op(7'b1000001, 5'd3,  9'b000100000, 1'b1, 1'b1);
    wait_empty();
    do_op(7'b1000001, 5'd20, 9'b000000000, 1'b1, 1'b1);
    wait_empty();
    do_op(7'b0000000, 5'd20, 9'b000000000, 1'b0, 1'b1);
    wait_empty();
    do_op(7'b1000001, 5'd9,  9'b000000000, 1'b1, 1'b1);
    wait_empty();
    do_op(7'b1111111, 5'd8,  9'b000000001, 1'b1, 1'b1);
    wait_empty();
    do_op(7'b0000001, 5'd16, 9'b000000000, 1'b1, 1'b1);
    wait_empty();
    do_op(7'b1010101, 5'd5,  9'b000001010, 1'b1, 1'b1);
    wait_empty();

    // Output stall with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(7'b1111111, 5'd0, 9'b111111100, 1'b0, 1'b1);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_fR", {23'd0, fR}, {23'd0, 9'b111111100});
      in_valid = i[0];
      fA = 7'b0000001;
      n  = 5'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    // Reset two cycles into an operation
    do_op(7'b1000001, 5'd2, 9'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_fR", {23'd0, fR}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("postrst_no_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_op(7'b0000010, 5'd1, 9'b000000100, 1'b0, 1'b1);
    wait_empty();

    // Back-to-back with out_ready held high
    do_op(7'b1000001, 5'd2, 9'b001000001, 1'b0, 1'b1);
    do_op(7'b1000001, 5'd3, 9'b000100000, 1'b1, 1'b1);
    do_op(7'b1111111, 5'd0, 9'b111111100, 1'b0, 1'b1);
    do_op(7'b1010101, 5'd5, 9'b000001010, 1'b1, 1'b1);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
